// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and register map constants for the MMIO UART transmitter
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [1:0] OFS_TXDATA = 2'd0;
  localparam logic [1:0] OFS_STATUS = 2'd1;
  localparam logic [1:0] OFS_CTRL   = 2'd2;

  localparam int ST_BUSY    = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_EMPTY   = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 8;

  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy count; push while full is accepted only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // When full, the write slot equals the head slot; the head is read out combinationally
  // before the edge overwrites it, so push+pop on a full FIFO keeps ordering intact.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

  // Storage array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO; UART_TX_IRQ_EN adds the irq output
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0400
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        tx
`ifdef UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int            CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int            FCNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CLKS_PER_BIT - 1);

  tx_state_t         state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              baud_done;

  logic              sel, wr, push, pop;
  logic [1:0]        ofs;
  logic              full, empty;
  logic [FCNT_W-1:0] fcount;
  logic [7:0]        fdout;
  logic              enable, overflow;
  logic              unused_bits;

  assign sel       = cs & (ALUResult[31:4] == BASE_ADDR[31:4]);
  assign ofs       = ALUResult[3:2];
  assign wr        = sel & MemWrite;
  assign push      = wr & (ofs == OFS_TXDATA);
  assign baud_done = (cnt == '0);
  // A pop happens from IDLE, or on the last STOP cycle so the next frame follows without a gap
  assign pop       = enable & ~empty & ((state == IDLE) | ((state == STOP) & baud_done));
  assign unused_bits = ^{ALUResult[1:0], WriteData[31:8]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (WriteData[7:0]),
    .dout  (fdout),
    .full  (full),
    .empty (empty),
    .count (fcount)
  );

  // Control and sticky overflow; a rejected push wins over a same-cycle W1C
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr && ofs == OFS_CTRL) enable <= WriteData[CTRL_EN];
      if (push && full && !pop)                               overflow <= 1'b1;
      else if (wr && ofs == OFS_STATUS && WriteData[ST_OVF])  overflow <= 1'b0;
    end
  end

`ifdef UART_TX_IRQ_EN
  logic irq_en;

  // Interrupt enable and registered "all sent" interrupt
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr && ofs == OFS_CTRL) irq_en <= WriteData[CTRL_IRQ_EN];
      irq <= irq_en & empty & (state == IDLE);
    end
  end
`endif

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pop) state_nxt = START;
      START:   if (baud_done) state_nxt = DATA;
      DATA:    if (baud_done && bit_idx == 3'd7) state_nxt = STOP;
      STOP:    if (baud_done) state_nxt = pop ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output: serial line level per state
  always_comb begin
    tx = 1'b1;
    case (state)
      START:   tx = 1'b0;
      DATA:    tx = shift[0];
      default: tx = 1'b1;
    endcase
  end

  // Baud counter, shift register and bit index
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= CNT_LOAD;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
    end else begin
      if (state == IDLE || baud_done) cnt <= CNT_LOAD;
      else                            cnt <= cnt - 1'b1;
      if (pop)                            shift <= fdout;
      else if (state == DATA && baud_done) shift <= {1'b0, shift[7:1]};
      if (state == START)                  bit_idx <= 3'd0;
      else if (state == DATA && baud_done) bit_idx <= bit_idx + 1'b1;
    end
  end

  // Combinational register read mux
  always_comb begin
    ReadData = '0;
    if (sel) begin
      case (ofs)
        OFS_STATUS: begin
          ReadData[ST_BUSY]                 = (state != IDLE);
          ReadData[ST_FULL]                 = full;
          ReadData[ST_EMPTY]                = empty;
          ReadData[ST_OVF]                  = overflow;
          ReadData[ST_CNT_LSB +: FCNT_W]    = fcount;
        end
        OFS_CTRL: begin
          ReadData[CTRL_EN] = enable;
`ifdef UART_TX_IRQ_EN
          ReadData[CTRL_IRQ_EN] = irq_en;
`endif
        end
        default: ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - self-checking bench for uart_tx_mmio with a frame-level reference model
module tb_uart_tx_mmio;

  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0400;

  logic        clk, reset, cs, MemWrite, tx;
  logic [31:0] ALUResult, WriteData, ReadData;
`ifdef UART_TX_IRQ_EN
  logic        irq;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  uart_tx_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .MemWrite  (MemWrite),
    .ALUResult (ALUResult),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .tx        (tx)
`ifdef UART_TX_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: pending bytes, and the exact line levels still to be driven for the current frame
  logic [7:0] m_fifo[$];
  bit         m_line[$];
  bit         m_en, m_irq_en, m_ovf, m_irq;
  logic [7:0] m_b;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_fifo.delete();
      m_line.delete();
      m_en = 0; m_irq_en = 0; m_ovf = 0; m_irq = 0;
    end else begin
      m_irq = m_irq_en && m_fifo.size() == 0 && m_line.size() == 0;
      if (m_line.size() > 0) void'(m_line.pop_front());
      if (m_line.size() == 0 && m_en && m_fifo.size() > 0) begin
        m_b = m_fifo.pop_front();
        for (int r = 0; r < CPB; r++) m_line.push_back(1'b0);
        for (int k = 0; k < 8; k++)
          for (int r = 0; r < CPB; r++) m_line.push_back(m_b[k]);
        for (int r = 0; r < CPB; r++) m_line.push_back(1'b1);
      end
      if (cs && MemWrite && ALUResult[31:4] == BASE[31:4]) begin
        case (ALUResult[3:2])
          2'd0: if (m_fifo.size() < DEPTH) m_fifo.push_back(WriteData[7:0]); else m_ovf = 1;
          2'd1: if (WriteData[3]) m_ovf = 0;
          2'd2: begin
            m_en = WriteData[0];
`ifdef UART_TX_IRQ_EN
            m_irq_en = WriteData[1];
`endif
          end
          default: ;
        endcase
      end
    end
  end

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic c);
    logic [31:0] r;
    r = 32'd0;
    if (c && a[31:4] == BASE[31:4]) begin
      case (a[3:2])
        2'd1: r = {16'd0, 8'(m_fifo.size()), 4'd0, m_ovf, m_fifo.size() == 0,
                   m_fifo.size() == DEPTH, m_line.size() != 0};
        2'd2: r = {30'd0, m_irq_en, m_en};
        default: r = 32'd0;
      endcase
    end
    return r;
  endfunction

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("tx_model", {31'd0, tx}, {31'd0, (m_line.size() > 0) ? m_line[0] : 1'b1});
    check("rdata_model", ReadData, model_read(ALUResult, cs));
`ifdef UART_TX_IRQ_EN
    check("irq_model", {31'd0, irq}, {31'd0, m_irq});
`endif
  end

  // Line recorder for offline frame decoding
  bit rec;
  bit rec_q[$];
  always @(negedge clk) if (rec) rec_q.push_back(tx);

  // Caller is anywhere inside a cycle; the write lands on the next edge
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cs = 1'b1; MemWrite = 1'b1; ALUResult = a; WriteData = d;
    @(posedge clk); #2;
    MemWrite = 1'b0; ALUResult = 32'h404; WriteData = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string name);
    ALUResult = a; #1;
    check(name, ReadData, e);
    ALUResult = 32'h404;
  endtask

  logic [9:0]  pat;
  logic [7:0]  exp_b [5];
  logic [7:0]  rx_b[$];
  int          rx_at[$];
  logic [7:0]  dec;
  int          idx;

  initial begin
    cs = 0; MemWrite = 0; ALUResult = 32'h404; WriteData = 0; reset = 0; rec = 0;
    repeat (3) @(posedge clk);
    #2 reset = 1; cs = 1;
    @(posedge clk); #2;

    // Reset state and address decode
    check("rst_tx", {31'd0, tx}, 32'd1);
    rd(32'h404, 32'h0000_0004, "rst_status");
    rd(32'h407, 32'h0000_0004, "status_low_bits_ignored");
    rd(32'h408, 32'h0, "rst_ctrl");
    rd(32'h400, 32'h0, "txdata_reads_0");
    rd(32'h40C, 32'h0, "reserved_reads_0");
    rd(32'h414, 32'h0, "outside_block");
    cs = 0; #1; check("cs_low_reads_0", ReadData, 32'h0); cs = 1;

    // Single frame 0x55, sampled at the first cycle of each bit
    pat = 10'b10_1010_1010;
    wr(32'h408, 32'h1);
    wr(32'h400, 32'h55);
    @(posedge clk); #1;
    for (int b = 0; b < 10; b++) begin
      check($sformatf("frame55_bit%0d", b), {31'd0, tx}, {31'd0, pat[b]});
      if (b == 0) check("busy_in_frame", ReadData, 32'h0000_0005);
      repeat (CPB) @(posedge clk);
      #1;
    end
    check("status_after_stop", ReadData, 32'h0000_0004);

    // Overflow with enable off, W1C, then full push+pop and back-to-back drain
    wr(32'h408, 32'h0);
    for (int i = 1; i <= 5; i++) wr(32'h400, i);
    rd(32'h404, 32'h0000_040A, "full_overflow");
    wr(32'h404, 32'h8);
    rd(32'h404, 32'h0000_0402, "overflow_cleared");
    rec = 1;
    wr(32'h408, 32'h1);
    wr(32'h400, 32'hAA);
    rd(32'h404, 32'h0000_0403, "push_pop_when_full");
    repeat (5 * 10 * CPB + 8) @(posedge clk);
    #1; rec = 0;
    check("status_drained", ReadData, 32'h0000_0004);

    exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hAA};
    idx = 0;
    while (idx + 10 * CPB <= rec_q.size()) begin
      if (rec_q[idx] == 1'b0) begin
        for (int k = 0; k < 8; k++) dec[k] = rec_q[idx + CPB * (k + 1) + CPB / 2];
        rx_b.push_back(dec);
        rx_at.push_back(idx);
        idx += 10 * CPB;
      end else idx++;
    end
    check("frame_count", rx_b.size(), 32'd5);
    for (int i = 0; i < rx_b.size() && i < 5; i++)
      check($sformatf("rx_byte%0d", i), {24'd0, rx_b[i]}, {24'd0, exp_b[i]});
    for (int i = 1; i < rx_at.size(); i++)
      check($sformatf("frame_gap%0d", i), rx_at[i] - rx_at[i-1], 10 * CPB);

    // Reset during DATA bit 3 of 0x34 (that bit is 0) with another byte queued
    wr(32'h408, 32'h1);
    wr(32'h400, 32'h34);
    wr(32'h400, 32'h81);
    repeat (16) @(posedge clk);
    #2;
    check("pre_reset_bit3", {31'd0, tx}, 32'd0);
    reset = 0; #1;
    check("reset_tx_high", {31'd0, tx}, 32'd1);
    rd(32'h404, 32'h0000_0004, "reset_fifo_empty");
    repeat (2) @(posedge clk);
    #2 reset = 1;
    repeat (60) @(posedge clk);
    #1;
    check("no_frame_after_reset", {31'd0, tx}, 32'd1);
    rd(32'h408, 32'h0, "enable_cleared");
    rd(32'h404, 32'h0000_0004, "idle_after_reset");

`ifdef UART_TX_IRQ_EN
    wr(32'h408, 32'h3);
    rd(32'h408, 32'h3, "ctrl_rw_irq");
    repeat (2) @(posedge clk); #1;
    check("irq_idle_empty", {31'd0, irq}, 32'd1);
    wr(32'h400, 32'h0F);
    @(posedge clk); #1;
    check("irq_low_in_frame", {31'd0, irq}, 32'd0);
    repeat (10 * CPB) @(posedge clk); #1;
    check("irq_low_at_stop_end", {31'd0, irq}, 32'd0);
    @(posedge clk); #1;
    check("irq_high_after_idle", {31'd0, irq}, 32'd1);
    wr(32'h408, 32'h1);
    @(posedge clk); #1;
    check("irq_cleared", {31'd0, irq}, 32'd0);
`else
    wr(32'h408, 32'h3);
    rd(32'h408, 32'h1, "ctrl_bit1_ignored");
`endif

    repeat (4) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
